// File: rtl/logconv_pkg.sv
// Shared constants and FSM encoding for the partial-sum accumulator.
//   IN_W_DEF / ACC_W_DEF / LEN_W_DEF : default widths of partial sum, accumulator, beat count
//   state_e                          : accumulator FSM states (IDLE=0, ACCUM=1, HOLD=2)
package logconv_pkg;

    localparam int unsigned IN_W_DEF  = 13;
    localparam int unsigned ACC_W_DEF = 16;
    localparam int unsigned LEN_W_DEF = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StHold  = 2'd2
    } state_e;

endpackage

// File: rtl/psum_accumulator_sat_add.sv
// Combinational saturating signed add: sum_o = clip(acc_i + sext(add_i)).
//   acc_i  [ACC_W] : signed accumulator operand
//   add_i  [IN_W]  : signed partial-sum operand, sign-extended before the add
//   sum_o  [ACC_W] : result clipped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]
//   clip_o         : high when the true sum fell outside that range
module sat_add #(
    parameter int unsigned IN_W  = 13,
    parameter int unsigned ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [IN_W-1:0]  add_i,
    output logic [ACC_W-1:0] sum_o,
    output logic             clip_o
);

    localparam logic [ACC_W-1:0] MaxPos = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MaxNeg = {1'b1, {(ACC_W-1){1'b0}}};

    // One guard bit is enough: both operands fit in ACC_W signed bits.
    logic [ACC_W:0] wide;

    always_comb begin
        wide   = {acc_i[ACC_W-1], acc_i} + {{(ACC_W+1-IN_W){add_i[IN_W-1]}}, add_i};
        clip_o = wide[ACC_W] ^ wide[ACC_W-1];
        if (clip_o) begin
            // Guard bit holds the true sign of the overflowed sum.
            sum_o = wide[ACC_W] ? MaxNeg : MaxPos;
        end else begin
            sum_o = wide[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates a configurable number of signed partial sums into one saturated result.
//   clk, rst_n             : clock (rising edge), asynchronous active-low reset
//   cfg_len   [LEN_W]      : beats per result, sampled on the first beat; 0 means 2^LEN_W
//   in_valid/in_ready      : input handshake; in_sum [IN_W] is the signed partial sum
//   out_valid/out_ready    : output handshake; out_data [ACC_W] signed result
//   out_sat                : some add of this result was clipped
//   busy                   : FSM not idle
module psum_accumulator
    import logconv_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_sat,
    output logic             busy
);

    localparam logic [LEN_W:0] LenOne = (LEN_W+1)'(1);
    localparam logic [LEN_W:0] LenMax = {1'b1, {LEN_W{1'b0}}};

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             sat_q, sat_d;

    logic             in_fire;
    logic [LEN_W:0]   eff_cfg_len, eff_len_q, cnt_inc;
    logic [ACC_W-1:0] add_sum;
    logic             add_clip;

    // A zero length field encodes the largest count, hence the extra bit.
    assign eff_cfg_len = (cfg_len == '0) ? LenMax : {1'b0, cfg_len};
    assign eff_len_q   = (len_q == '0) ? LenMax : {1'b0, len_q};
    assign cnt_inc     = cnt_q + LenOne;
    assign in_fire     = in_valid & in_ready;

    sat_add #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc_i  (acc_q),
        .add_i  (in_sum),
        .sum_o  (add_sum),
        .clip_o (add_clip)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_fire) begin
                    state_d = (eff_cfg_len == LenOne) ? StHold : StAccum;
                end
            end
            StAccum: begin
                if (in_fire && (cnt_inc == eff_len_q)) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend on state only, so there is no valid->ready combinational path.
    always_comb begin
        in_ready  = (state_q != StHold);
        out_valid = (state_q == StHold);
        busy      = (state_q != StIdle);
        out_data  = acc_q;
        out_sat   = sat_q;
    end

    // Datapath next-state: only an accepted beat touches acc/cnt/len/sat.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        len_d = len_q;
        sat_d = sat_q;
        if (in_fire) begin
            if (state_q == StIdle) begin
                acc_d = {{(ACC_W-IN_W){in_sum[IN_W-1]}}, in_sum};
                cnt_d = LenOne;
                len_d = cfg_len;
                sat_d = 1'b0;
            end else begin
                acc_d = add_sum;
                cnt_d = cnt_inc;
                sat_d = sat_q | add_clip;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
            sat_q <= sat_d;
        end
    end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter IN_W, default 13, meaning the width of the two's-complement partial sum delivered by the adder tree.
REQ-002 SHALL have parameter ACC_W, default 16, meaning the width of the signed accumulator and result (ACC_W > IN_W).
REQ-003 SHALL have parameter LEN_W, default 4, meaning the width of the beat-count configuration.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cfg_len  input  LEN_W  partial sums per result; 0 means 2^LEN_W.
REQ-007 SHALL have port in_valid  input  1  in_sum valid.
REQ-008 SHALL have port in_ready  output  1  block accepts in_sum.
REQ-009 SHALL have port in_sum  input  IN_W  signed partial sum from the adder tree.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out_data  output  ACC_W  signed accumulated result.
REQ-013 SHALL have port out_sat  output  1  saturation occurred during this result.
REQ-014 SHALL have port busy  output  1  accumulation in progress (state != IDLE).

Function
REQ-015 SHALL transfer an input beat only on a rising edge where in_valid && in_ready, and an output only where out_valid && out_ready.
REQ-016 SHALL implement FSM states IDLE, ACCUM, HOLD; in_ready = 1 in IDLE and ACCUM, 0 in HOLD; out_valid = 1 only in HOLD.
REQ-017 SHALL, on a beat in IDLE: latch cfg_len into len_q; load acc = sign-extended in_sum; set cnt = 1; clear the sticky sat flag; go to HOLD if the effective len is 1, else go to ACCUM.
REQ-018 SHALL ignore cfg_len changes except on the first beat of a result.
REQ-019 SHALL, on each beat in ACCUM: set acc = sat(acc + sext(in_sum)); increment cnt; go to HOLD when the new cnt equals the effective len.
REQ-020 SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clipped add sets the sticky sat flag, and subsequent adds continue from the clipped value.
REQ-021 SHALL drive out_data = acc and out_sat = sat flag in HOLD, holding both stable until the handshake.
REQ-022 SHALL have a latency of 1 cycle: out_valid rises on the edge that accepts the final beat.
REQ-023 SHALL, on the output handshake, go HOLD -> IDLE; no input is accepted in that cycle, so a one-cycle bubble is mandatory.
REQ-024 SHALL keep cnt and acc unchanged in cycles without an input transfer, with no timeout.
REQ-025 SHALL make in_ready independent of in_valid, and out_valid independent of out_ready (no combinational valid->ready path).

Reset
REQ-026 SHALL, on rst_n low and asynchronously: state = IDLE, acc = 0, cnt = 0, len_q = 0, sat = 0; outputs in_ready = 1 (after release), out_valid = 0, out_data = 0, out_sat = 0, busy = 0.
REQ-027 SHALL discard any partial or held result on reset mid-operation, without emitting it.
REQ-028 SHALL accept the first beat on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place the FSM state encoding (IDLE=0, ACCUM=1, HOLD=2) and the default IN_W/ACC_W/LEN_W constants in shared package logconv_pkg.
REQ-030 SHALL implement the saturating signed add with clip flag as combinational sub-module sat_add (inputs ACC_W and IN_W; outputs ACC_W result and clip).

Verification
REQ-031 SHALL cover: cfg_len=4, beats 10, -3, 100, -200 back-to-back with out_ready=1 -> out_data=-93, out_sat=0, out_valid one cycle after beat 4, in_ready=0 for that cycle.
REQ-032 SHALL cover: cfg_len=0 (16 beats), each in_sum=4095 -> out_data=32767, out_sat=1.
REQ-033 SHALL cover: cfg_len=2, beats -4096, -4096 -> out_data=-8192, out_sat=0; next result cfg_len=1, beat 7 -> out_data=7, sat cleared.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles in HOLD -> out_valid and out_data stable, in_ready=0, in_valid beats not consumed.
REQ-035 SHALL cover: cfg_len=3, assert rst_n=0 after 2 beats -> outputs at reset values immediately; next 3 beats 1, 1, 1 -> out_data=3.
REQ-036 SHALL cover: random in_valid/out_ready gaps over 1000 results -> matches a scoreboard model of REQ-017 to REQ-020.
